// File: rtl/cache_mem_arbiter.sv
// Arbitrates the unified memory port between the I-cache fill, D-cache fill and
// write-through store paths; fills hold the port for a whole block burst.
module cache_mem_arbiter #(
    parameter int BEATS  = 8,
    parameter int BEAT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_data_valid,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    output logic        d_gnt,
    output logic        d_data_valid,
    input  logic        st_req,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic        st_ack,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic        memory_data_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        GRANT_I = 2'd2,
        GRANT_D = 2'd3
    } state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              last_fill_q, last_fill_d;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_fill_d  = last_fill_q;
        i_gnt        = 1'b0;
        i_data_valid = 1'b0;
        d_gnt        = 1'b0;
        d_data_valid = 1'b0;
        st_ack       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_in  = 16'h0000;

        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (st_req)
                    state_d = WRITE;
                else if (i_req && d_req)
                    state_d = last_fill_q ? GRANT_I : GRANT_D;
                else if (i_req)
                    state_d = GRANT_I;
                else if (d_req)
                    state_d = GRANT_D;
            end

            WRITE: begin
                st_ack      = 1'b1;
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = st_addr;
                mem_data_in = st_data;
                beat_cnt_d  = '0;
                state_d     = IDLE;
            end

            GRANT_I: begin
                i_gnt        = 1'b1;
                mem_en       = 1'b1;
                mem_addr     = i_addr;
                i_data_valid = memory_data_valid;
                // A dropped request ends the grant even on what would be the last beat.
                if (!i_req) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (memory_data_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        beat_cnt_d  = '0;
                        last_fill_d = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end

            GRANT_D: begin
                d_gnt        = 1'b1;
                mem_en       = 1'b1;
                mem_addr     = d_addr;
                d_data_valid = memory_data_valid;
                if (!d_req) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (memory_data_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        beat_cnt_d  = '0;
                        last_fill_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // last_fill resets to "I served last" so that D wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            last_fill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            last_fill_q <= last_fill_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized and directed bench for cache_mem_arbiter against a burst-level
// ownership model (who owns memory, beats still owed, whose turn on a tie).
module tb_cache_mem_arbiter;

    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, st_req, memory_data_valid;
    logic [15:0] i_addr, d_addr, st_addr, st_data;
    logic        i_gnt, i_data_valid, d_gnt, d_data_valid, st_ack, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_in;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.BEATS(BEATS), .BEAT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_valid(i_data_valid),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_data_valid(d_data_valid),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .memory_data_valid(memory_data_valid)
    );

    int checks = 0;
    int fails  = 0;

    // Model: owner 0 = nobody, 1 = store, 2 = I fill, 3 = D fill.
    int owner;
    int beats_owed;
    bit i_next_on_tie;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_vec();
        return 64'({i_gnt, i_data_valid, d_gnt, d_data_valid, st_ack, mem_en, mem_wr,
                    mem_addr, mem_data_in});
    endfunction

    function automatic logic [63:0] exp_vec();
        logic ig, idv, dg, ddv, sa, en, wr;
        logic [15:0] a, dat;
        {ig, idv, dg, ddv, sa, en, wr} = '0;
        a = '0;
        dat = '0;
        if (owner == 1) begin
            sa = 1; en = 1; wr = 1; a = st_addr; dat = st_data;
        end else if (owner == 2) begin
            ig = 1; en = 1; a = i_addr; idv = memory_data_valid;
        end else if (owner == 3) begin
            dg = 1; en = 1; a = d_addr; ddv = memory_data_valid;
        end
        return 64'({ig, idv, dg, ddv, sa, en, wr, a, dat});
    endfunction

    function automatic void model_reset();
        owner = 0;
        beats_owed = BEATS;
        i_next_on_tie = 1'b0;
    endfunction

    function automatic void model_edge();
        bit held;
        if (owner == 0) begin
            beats_owed = BEATS;
            if (st_req) owner = 1;
            else if (i_req && d_req) owner = i_next_on_tie ? 2 : 3;
            else if (i_req) owner = 2;
            else if (d_req) owner = 3;
        end else if (owner == 1) begin
            owner = 0;
        end else begin
            held = (owner == 2) ? i_req : d_req;
            if (!held) begin
                owner = 0;
                beats_owed = BEATS;
            end else if (memory_data_valid) begin
                beats_owed--;
                if (beats_owed == 0) begin
                    i_next_on_tie = (owner == 3);
                    owner = 0;
                    beats_owed = BEATS;
                end
            end
        end
    endfunction

    task automatic cyc(input string tag);
        #1 chk_eq(tag, obs_vec(), exp_vec());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {i_req, d_req, st_req, memory_data_valid} = '0;
        i_addr = '0; d_addr = '0; st_addr = '0; st_data = '0;
        model_reset();
        #1 chk_eq("reset_outputs", obs_vec(), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Hold valid high and count cycles the chosen side keeps its grant.
    task automatic count_beats(input string tag, input bit side_d, output int n);
        int g;
        n = 0;
        memory_data_valid = 1'b1;
        for (g = 0; g < 40; g++) begin
            if (side_d ? d_gnt : i_gnt) n++;
            else if (n > 0) break;
            cyc(tag);
        end
        if (g == 40) chk_eq({tag, "_timeout"}, 64'(g), 64'd0);
        memory_data_valid = 1'b0;
    endtask

    initial begin
        int n;
        int order[$];
        bit pi, pd;

        // Single I fill with gapped valid pulses.
        do_reset();
        i_req = 1; i_addr = 16'h1230;
        cyc("t1_req");
        chk_eq("t1_gnt_addr", 64'({i_gnt, mem_en, mem_wr, mem_addr}), 64'({3'b110, 16'h1230}));
        for (int k = 0; k < BEATS; k++) begin
            memory_data_valid = 1;
            #1 chk_eq("t1_ivalid", 64'({i_data_valid, d_data_valid}), 64'b10);
            cyc("t1_beat");
            memory_data_valid = 0;
            if (k != BEATS - 1) cyc("t1_gap");
        end
        chk_eq("t1_release", 64'(i_gnt), 64'd0);
        i_req = 0;
        cyc("t1_idle");

        // Tie from reset: D first, then strict alternation with one idle bubble.
        do_reset();
        i_req = 1; d_req = 1; memory_data_valid = 1;
        i_addr = 16'h1000; d_addr = 16'h2000;
        pi = 0; pd = 0;
        for (int c = 0; c < 45; c++) begin
            if (i_gnt && !pi) order.push_back(1);
            if (d_gnt && !pd) order.push_back(2);
            pi = i_gnt; pd = d_gnt;
            cyc("t2_tie");
        end
        memory_data_valid = 0;
        chk_eq("t2_grants", 64'(order.size() >= 4), 64'd1);
        if (order.size() >= 4)
            chk_eq("t2_order", 64'({order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}),
                   64'({2'd2, 2'd1, 2'd2, 2'd1}));

        // Store beats a pending D fill.
        do_reset();
        st_req = 1; st_addr = 16'h0040; st_data = 16'hBEEF; d_req = 1; d_addr = 16'h3300;
        cyc("t3_req");
        st_req = 0;
        chk_eq("t3_write", 64'({st_ack, mem_en, mem_wr, d_gnt, mem_addr, mem_data_in}),
               64'({4'b1110, 16'h0040, 16'hBEEF}));
        cyc("t3_write_cyc");
        chk_eq("t3_bubble", 64'({st_ack, d_gnt, mem_en}), 64'd0);
        cyc("t3_bubble_cyc");
        chk_eq("t3_dgnt", 64'(d_gnt), 64'd1);

        // Abort D after 3 beats; re-request needs the full burst, tie order unchanged.
        memory_data_valid = 1;
        for (int k = 0; k < 3; k++) cyc("t4_beat");
        memory_data_valid = 0;
        d_req = 0;
        cyc("t4_abort");
        chk_eq("t4_idle", 64'(d_gnt), 64'd0);
        d_req = 1; i_req = 1;
        cyc("t4_rereq");
        chk_eq("t4_d_still_first", 64'({i_gnt, d_gnt}), 64'b01);
        count_beats("t4_burst", 1'b1, n);
        chk_eq("t4_full_beats", 64'(n), 64'(BEATS));
        d_req = 0;
        cyc("t4_after");
        chk_eq("t4_i_next", 64'(i_gnt), 64'd1);
        i_req = 0;
        cyc("t4_done");

        // Asynchronous reset at beat 5.
        do_reset();
        i_req = 1; i_addr = 16'h0A0A;
        cyc("t5_req");
        memory_data_valid = 1;
        for (int k = 0; k < 5; k++) cyc("t5_beat");
        #3 rst_n = 0;
        model_reset();
        #1 chk_eq("t5_async_zero", obs_vec(), 64'd0);
        @(posedge clk);
        #1 rst_n = 1;
        count_beats("t5_fresh", 1'b0, n);
        chk_eq("t5_fresh_beats", 64'(n), 64'(BEATS));
        i_req = 0;
        cyc("t5_done");

        // Valid while idle and during a store is dropped.
        memory_data_valid = 1;
        #1 chk_eq("t6_idle_valid", 64'({i_data_valid, d_data_valid}), 64'd0);
        cyc("t6_idle");
        memory_data_valid = 0; st_req = 1; st_addr = 16'h0011; st_data = 16'h2222;
        cyc("t6_streq");
        st_req = 0; memory_data_valid = 1;
        #1 chk_eq("t6_write_valid", 64'({st_ack, i_data_valid, d_data_valid}), 64'b100);
        cyc("t6_write");
        memory_data_valid = 0; i_req = 1;
        cyc("t6_ireq");
        count_beats("t6_burst", 1'b0, n);
        chk_eq("t6_full_beats", 64'(n), 64'(BEATS));
        i_req = 0;
        cyc("t6_done");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) i_req = ~i_req;
            if ($urandom_range(0, 11) == 0) d_req = ~d_req;
            st_req = ($urandom_range(0, 9) == 0);
            memory_data_valid = $urandom_range(0, 1);
            i_addr = 16'($urandom); d_addr = 16'($urandom);
            st_addr = 16'($urandom); st_data = 16'($urandom);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
